// File: rtl/param_register_file.sv
// param_register_file
//   Architectural register file with an integrated per-register busy
//   scoreboard. Decode reads operands and marks the destination of an issuing
//   instruction busy. Writeback writes results and may clear the busy bit.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   : same-cycle write-to-read forwarding of data and busy-clear.
//   Undefined : reads reflect stored state only.
//
// Parameters
//   XLEN     data width of each register
//   NUM_REGS number of registers (power of 2, >= 2); AW = $clog2(NUM_REGS)
//   NUM_RD   read ports (1..4)
//   NUM_WR   write ports (1..2); the highest port wins an address conflict
//   ZERO_REG 1: register 0 reads as 0, ignores writes and is never busy
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   wr_en        per-port write enable
//   wr_addr      packed write addresses, port k at [k*AW +: AW]
//   wr_data      packed write data, port k at [k*XLEN +: XLEN]
//   wr_clr_busy  per-port clear of the destination busy bit (only with wr_en)
//   iss_en       mark iss_addr busy
//   iss_addr     destination of the issuing instruction
//   rd_addr      packed read addresses
//   rd_data      packed read data (combinational)
//   rd_busy      busy bit per read port (combinational)
//   busy_any     registered OR of the post-update busy vector
module param_register_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic [NUM_WR-1:0]      wr_clr_busy,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  output logic                   busy_any
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           busy_q, busy_d;
  logic                          busy_any_q;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Next state. Write ports are applied in ascending order so the highest
  // port wins a same-address conflict. Issue is applied after the clears so
  // a new producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && !is_zero(wr_addr[k*AW +: AW])) begin
        regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
        if (wr_clr_busy[k]) busy_d[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && !is_zero(iss_addr)) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  assign busy_any = busy_any_q;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[j*AW +: AW];

    always_comb begin
      d = regs_q[a];
      b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      // Forward in-flight writes; later ports override earlier ones. A
      // same-cycle issue to this register means a new producer, so the
      // clear is not forwarded.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) begin
          d = wr_data[k*XLEN +: XLEN];
          if (wr_clr_busy[k] && !(iss_en && (iss_addr == a))) b = 1'b0;
        end
      end
`endif
      if (is_zero(a)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[j*XLEN +: XLEN] = d;
    assign rd_busy[j]              = b;
  end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
  localparam int XLEN = 32, NR = 32, NRD = 2, NWR = 2, AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*XLEN-1:0]   wr_data;
  logic [NWR-1:0]        wr_clr_busy;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  busy_any;

  param_register_file #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD),
                        .NUM_WR(NWR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_clr_busy(wr_clr_busy), .iss_en(iss_en),
    .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d0, d1;
    logic [1:0]  b;
    logic        ba;
  } exp_t;

  exp_t q[$];
  logic chk_req = 1'b0;
  int   n_vec = 0, n_miss = 0;

  // Monitor: at each negedge where the driver flagged a check, pop and compare.
  always @(negedge clk) begin
    if (chk_req) begin
      if (q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL scoreboard_underflow: check requested with empty queue");
      end else begin
        exp_t e;
        e = q.pop_front();
        n_vec++;
        if (rd_data[31:0] !== e.d0 || rd_data[63:32] !== e.d1 ||
            rd_busy !== e.b || busy_any !== e.ba) begin
          n_miss++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b any=%b, want d0=%h d1=%h busy=%b any=%b",
                   e.name, rd_data[31:0], rd_data[63:32], rd_busy, busy_any,
                   e.d0, e.d1, e.b, e.ba);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic idle;
    rst = 1'b0; wr_en = '0; wr_clr_busy = '0; iss_en = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [31:0] d,
                    input logic clr);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = a;
    wr_data[k*XLEN +: XLEN] = d;
    wr_clr_busy[k] = clr;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic expect_v(input string n, input logic [31:0] d0,
                          input logic [31:0] d1, input logic [1:0] b,
                          input logic ba);
    exp_t e;
    e.name = n; e.d0 = d0; e.d1 = d1; e.b = b; e.ba = ba;
    q.push_back(e);
    chk_req = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;
    rst = 1'b1;
    tick(); tick();
    idle(); rd(5'd0, 5'd5);
    expect_v("reset_state", 32'h0, 32'h0, 2'b00, 1'b0);

    // Reset clear: write + issue x5, then reset.
    tick(); wr(0, 5'd5, 32'hDEADBEEF, 1'b0); iss(5'd5); rd(5'd5, 5'd5);
    tick(); idle(); rd(5'd5, 5'd5);
    expect_v("x5_written", 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1'b1);
    tick(); rst = 1'b1;
    expect_v("rst_shows_stored", 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1'b1);
    tick(); idle();
    expect_v("rst_cleared", 32'h0, 32'h0, 2'b00, 1'b0);

    // x0 guard.
    tick(); wr(0, 5'd0, 32'h12345678, 1'b0); iss(5'd0); rd(5'd0, 5'd0);
    expect_v("x0_same_cycle", 32'h0, 32'h0, 2'b00, 1'b0);
    tick(); idle();
    expect_v("x0_after", 32'h0, 32'h0, 2'b00, 1'b0);

    // Dual-write conflict on x7: port1 wins.
    tick(); wr(0, 5'd7, 32'h11111111, 1'b0); wr(1, 5'd7, 32'h22222222, 1'b0);
    rd(5'd7, 5'd7);
    expect_v("dual_same", BYP ? 32'h22222222 : 32'h0,
             BYP ? 32'h22222222 : 32'h0, 2'b00, 1'b0);
    tick(); idle();
    expect_v("dual_next", 32'h22222222, 32'h22222222, 2'b00, 1'b0);

    // Scoreboard on x3.
    tick(); iss(5'd3); rd(5'd3, 5'd0);
    expect_v("iss_same", 32'h0, 32'h0, 2'b00, 1'b0);
    tick(); idle();
    expect_v("iss_next", 32'h0, 32'h0, 2'b01, 1'b1);
    tick();
    expect_v("iss_hold", 32'h0, 32'h0, 2'b01, 1'b1);
    tick(); wr(0, 5'd3, 32'hA5A5A5A5, 1'b1); rd(5'd3, 5'd3);
    expect_v("wb_same", BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0,
             BYP ? 2'b00 : 2'b11, 1'b1);
    tick(); idle();
    expect_v("wb_next", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0);

    // Set/clear collision on x9: set wins.
    tick(); iss(5'd9); rd(5'd9, 5'd9);
    tick(); idle();
    expect_v("x9_busy", 32'h0, 32'h0, 2'b11, 1'b1);
    tick(); wr(1, 5'd9, 32'h99999999, 1'b1); iss(5'd9);
    expect_v("coll_same", BYP ? 32'h99999999 : 32'h0,
             BYP ? 32'h99999999 : 32'h0, 2'b11, 1'b1);
    tick(); idle();
    expect_v("coll_next", 32'h99999999, 32'h99999999, 2'b11, 1'b1);
    tick(); wr(1, 5'd9, 32'h99999999, 1'b1);
    tick(); idle();
    expect_v("x9_cleared", 32'h99999999, 32'h99999999, 2'b00, 1'b0);

    // wr_clr_busy without wr_en is ignored.
    tick(); iss(5'd10); rd(5'd10, 5'd10);
    tick(); idle(); wr_addr[0 +: AW] = 5'd10; wr_clr_busy[0] = 1'b1;
    tick(); idle();
    expect_v("clr_without_en", 32'h0, 32'h0, 2'b11, 1'b1);
    tick(); wr(0, 5'd10, 32'h0000000A, 1'b1);
    tick(); idle();
    expect_v("x10_cleared", 32'h0000000A, 32'h0000000A, 2'b00, 1'b0);

    // Bypass on x4 seen by both ports.
    tick(); wr(0, 5'd4, 32'h0BADF00D, 1'b0);
    tick(); idle(); wr(1, 5'd4, 32'hCAFEF00D, 1'b0); rd(5'd4, 5'd4);
    expect_v("byp_same", BYP ? 32'hCAFEF00D : 32'h0BADF00D,
             BYP ? 32'hCAFEF00D : 32'h0BADF00D, 2'b00, 1'b0);
    tick(); idle();
    expect_v("byp_next", 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 1'b0);

    // Independent ports on different registers.
    tick(); rd(5'd4, 5'd7);
    expect_v("ports_indep", 32'hCAFEF00D, 32'h22222222, 2'b00, 1'b0);

    // Reset discards a same-cycle write and issue.
    tick(); rst = 1'b1; wr(0, 5'd6, 32'h66666666, 1'b0); iss(5'd6);
    tick(); idle(); rd(5'd6, 5'd4);
    expect_v("rst_discards_op", 32'h0, 32'h0, 2'b00, 1'b0);

    tick(); tick();
    if (q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_leftover: %0d unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
